// File: rtl/cic_interpolator.sv
// Purpose: 3-stage CIC interpolator, signed WIDTH-bit samples upsampled by 2^LOG2_RATIO, unity DC gain.
// Latency: a sample taken in slot cycle T first reaches d_out at T+5; one output sample every cycle.
// Backpressure: in_ready is high only in the slot cycle (cnt==0); a missed slot reuses the last sample and sets underrun.
// Optional rounding before the final shift is enabled by defining CIC_ROUND_EN (default: truncating shift).
module cic_interpolator #(
    parameter int LOG2_RATIO = 3,
    parameter int WIDTH      = 8
) (
    input  logic                    osc_clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] d_out,
    output logic                    d_clk,
    output logic                    underrun,
    input  logic                    underrun_clr
);

    localparam int ACC   = WIDTH + 3 * LOG2_RATIO;
    localparam int SHIFT = 2 * LOG2_RATIO;

    // Output clip limits carried at ACC+1 bits so the comparison is sign-correct.
    localparam logic signed [ACC:0] OUT_MAX = (ACC + 1)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC:0] OUT_MIN = ~OUT_MAX;
`ifdef CIC_ROUND_EN
    localparam logic signed [ACC:0] ROUND   = (ACC + 1)'(1 << (SHIFT - 1));
`endif

    logic [LOG2_RATIO-1:0]   cnt_q, cnt_d;
    logic                    slot;
    logic signed [WIDTH-1:0] last_q, samp;
    logic signed [ACC-1:0]   x, c1, c2, c3;
    logic signed [ACC-1:0]   x_z_q, c1_z_q, c2_z_q, comb_out_q;
    logic                    slot_dly_q;
    logic signed [ACC-1:0]   up;
    logic signed [ACC-1:0]   i1_q, i2_q, i3_q;
    logic signed [ACC:0]     biased, shifted;
    logic signed [WIDTH-1:0] sat_d, d_out_q;
    logic                    underrun_q, underrun_d;

    // Slot selection, comb arithmetic and zero-stuffing at the slot rate.
    always_comb begin
        cnt_d = cnt_q + LOG2_RATIO'(1);
        slot  = (cnt_q == '0);
        samp  = in_valid ? in_data : last_q;
        x     = {{(ACC - WIDTH){samp[WIDTH-1]}}, samp};
        c1    = x - x_z_q;
        c2    = c1 - c1_z_q;
        c3    = c2 - c2_z_q;
        up    = slot_dly_q ? comb_out_q : '0;
    end

    // Sticky underrun: a missed slot wins over a clear in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        if (slot && !in_valid) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // Final scaling by R^2 (optionally rounded) and clip to the output range.
    always_comb begin
`ifdef CIC_ROUND_EN
        biased = {i3_q[ACC-1], i3_q} + ROUND;
`else
        biased = {i3_q[ACC-1], i3_q};
`endif
        shifted = biased >>> SHIFT;
        sat_d   = shifted[WIDTH-1:0];
        if (shifted > OUT_MAX) begin
            sat_d = OUT_MAX[WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            sat_d = OUT_MIN[WIDTH-1:0];
        end
    end

    // Phase counter, slot-rate comb delays, sample hold and underrun flag.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            cnt_q      <= '0;
            last_q     <= '0;
            x_z_q      <= '0;
            c1_z_q     <= '0;
            c2_z_q     <= '0;
            comb_out_q <= '0;
            slot_dly_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slot_dly_q <= slot;
            underrun_q <= underrun_d;
            if (slot) begin
                last_q     <= samp;
                x_z_q      <= x;
                c1_z_q     <= c1;
                c2_z_q     <= c2;
                comb_out_q <= c3;
            end
        end
    end

    // High-rate integrator cascade and registered output; wrap-around is intended.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d_out_q <= '0;
        end else begin
            i1_q    <= i1_q + up;
            i2_q    <= i2_q + i1_q;
            i3_q    <= i3_q + i2_q;
            d_out_q <= sat_d;
        end
    end

    assign in_ready = slot;
    assign d_clk    = slot_dly_q;
    assign d_out    = d_out_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: directed steps plus a randomized stream checked against an FIR reference
// built from the convolution of three length-R boxcars applied to the slot samples.
module tb_cic_interpolator;

    localparam int L     = 3;
    localparam int W     = 8;
    localparam int R     = 1 << L;
    localparam int SHIFT = 2 * L;
    localparam int HLEN  = 3 * (R - 1) + 1;

    logic                osc_clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] d_out;
    logic                d_clk;
    logic                underrun;
    logic                underrun_clr = 1'b0;

    always #5 osc_clk = ~osc_clk;

    cic_interpolator #(.LOG2_RATIO(L), .WIDTH(W)) dut (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d_out        (d_out),
        .d_clk        (d_clk),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    int h [HLEN];
    int taps [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};
    int slot_t [$];
    int slot_x [$];
    int c;
    int last_x;
    bit und_m;
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            fails = fails + 1;
            $error("FAIL %s @cycle %0d: got %0d expected %0d", tag, c, obs, exp);
        end
    endtask

    // Reference: every slot contributes x * h[k] to the output k cycles after its 5-cycle pipeline delay.
    function automatic int model_dout(input int cc);
        longint acc = 0;
        for (int k = 0; k < slot_t.size(); k++) begin
            int j = cc - 5 - slot_t[k];
            if (j >= 0 && j < HLEN) acc += longint'(slot_x[k]) * longint'(h[j]);
        end
`ifdef CIC_ROUND_EN
        acc += longint'(1) << (SHIFT - 1);
`endif
        acc = acc >>> SHIFT;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return int'(acc);
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        underrun_clr = 1'b0;
        @(posedge osc_clk);
        #1;
        reset  = 1'b0;
        slot_t.delete();
        slot_x.delete();
        c      = 0;
        last_x = 0;
        und_m  = 1'b0;
        check("rst_d_out", $signed(d_out), 0);
        check("rst_d_clk", d_clk, 0);
        check("rst_underrun", underrun, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    task automatic cyc(input bit v, input int d, input bit clr);
        bit slot;
        in_valid     = v;
        in_data      = d[W-1:0];
        underrun_clr = clr;
        slot = (c % R == 0);
        check("in_ready", in_ready, int'(slot));
        if (slot) begin
            if (v) last_x = d;
            slot_t.push_back(c);
            slot_x.push_back(last_x);
        end
        if (slot && !v) und_m = 1'b1;
        else if (clr) und_m = 1'b0;
        @(posedge osc_clk);
        #1;
        c = c + 1;
        check("d_out", $signed(d_out), model_dout(c));
        check("d_clk", d_clk, int'(c >= 1 && (c - 1) % R == 0));
        check("underrun", underrun, int'(und_m));
    endtask

    // Impulse at the first slot, then zeros; taps compared directly against the published response.
    task automatic impulse(input int amp, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int j;
            int e;
            cyc(1'b1, (i == 0) ? amp : 0, 1'b0);
            j = c - 5;
            e = 0;
            if (j >= 0 && j < 22) begin
                if (amp == 64) e = taps[j];
`ifdef CIC_ROUND_EN
                else e = (taps[j] >= 32) ? 1 : 0;
`endif
            end
            check("imp_tap", $signed(d_out), e);
        end
    endtask

    initial begin
        // Reference taps: triple boxcar convolution of length R.
        for (int j = 0; j < HLEN; j++) h[j] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int e = 0; e < R; e++)
                    h[a + b + e] += 1;

        // Zero stream.
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1, 0, 1'b0);

        // Impulse of 64.
        do_reset();
        impulse(64, 40);

        // Step to +100: monotonic rise, exact settle from T+26.
        do_reset();
        begin
            int prev = 0;
            for (int i = 0; i < 60; i++) begin
                cyc(1'b1, 100, 1'b0);
                check("step_mono", int'($signed(d_out) >= prev), 1);
                prev = $signed(d_out);
                if (c >= 26) check("step_100", $signed(d_out), 100);
            end
        end

        // Step to -128: settles without wrap.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, -128, 1'b0);
            if (c >= 26) check("step_m128", $signed(d_out), -128);
        end

        // Underrun behaviour on a steady stream of 50.
        do_reset();
        for (int i = 0; i < 48; i++) cyc(1'b1, 50, 1'b0);
        cyc(1'b0, 0, 1'b0);
        check("und_set", underrun, 1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 50, 1'b0);
        check("und_hold_out", $signed(d_out), 50);
        cyc(1'b1, 50, 1'b0);
        cyc(1'b1, 50, 1'b1);
        check("und_clr", underrun, 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 50, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("und_set_wins", underrun, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 50, 1'b0);
            check("und_steady", $signed(d_out), 50);
        end

        // Reset in the middle of a frame with live integrators, then a clean impulse.
        do_reset();
        cyc(1'b1, 64, 1'b0);
        while (c < 20) cyc(1'b1, 0, 1'b0);
        check("mid_nonzero", int'(d_out != 0), 1);
        do_reset();
        impulse(64, 40);

        // Unit impulse: only visible with rounding.
        do_reset();
        impulse(1, 40);

        // Randomized stream with missed slots, ignored off-slot valids and random clears.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit v   = ($urandom_range(0, 7) != 0);
            int d   = int'($urandom_range(0, 255)) - 128;
            bit clr = ($urandom_range(0, 15) == 0);
            cyc(v, d, clr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
